// File: rtl/sb_pkg.sv
// Shared constants and header-building helper for the sideband message header builder.
package sb_pkg;

  localparam int HDR_W = 64;

  localparam logic [4:0] OPC_MSG_NODATA = 5'b10010;
  localparam logic [4:0] OPC_MSG_DATA64 = 5'b11011;

  localparam logic [2:0] DEF_SRCID = 3'b010;
  localparam logic [2:0] DEF_DSTID = 3'b110;

  localparam int OPC_LSB     = 0;
  localparam int MSGCODE_LSB = 14;
  localparam int SRCID_LSB   = 29;
  localparam int SUBCODE_LSB = 32;
  localparam int INFO_LSB    = 40;
  localparam int DSTID_LSB   = 56;
  localparam int DP_BIT      = 62;
  localparam int CP_BIT      = 63;

  // Reserved fields stay zero; CP makes the full header even parity.
  function automatic logic [HDR_W-1:0] build_header(
    input logic        has_data,
    input logic        dp,
    input logic [7:0]  code,
    input logic [7:0]  subcode,
    input logic [15:0] info,
    input logic [2:0]  srcid,
    input logic [2:0]  dstid
  );
    logic [HDR_W-1:0] h;
    h = '0;
    h[OPC_LSB +: 5]      = has_data ? OPC_MSG_DATA64 : OPC_MSG_NODATA;
    h[MSGCODE_LSB +: 8]  = code;
    h[SRCID_LSB +: 3]    = srcid;
    h[SUBCODE_LSB +: 8]  = subcode;
    h[INFO_LSB +: 16]    = info;
    h[DSTID_LSB +: 3]    = dstid;
    h[DP_BIT]            = has_data & dp;
    h[CP_BIT]            = ^h[CP_BIT-1:0];
    return h;
  endfunction

endpackage

// File: rtl/sb_rr_arbiter.sv
// Round-robin arbiter: grants the first valid channel at or after rr_ptr,
// and advances rr_ptr past the winner whenever a grant is issued.
module sb_rr_arbiter #(
  parameter int N_CH = 4,
  localparam int IDX_W = $clog2(N_CH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [N_CH-1:0]  valid_i,
  input  logic             enable_i,
  output logic [N_CH-1:0]  grant_o,
  output logic [IDX_W-1:0] grant_idx_o
);

  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             found;

  always_comb begin
    grant_idx_o = '0;
    found       = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (!found && valid_i[(int'(rr_ptr_q) + i) % N_CH]) begin
        found       = 1'b1;
        grant_idx_o = IDX_W'((int'(rr_ptr_q) + i) % N_CH);
      end
    end
    grant_o  = '0;
    rr_ptr_d = rr_ptr_q;
    if (enable_i && found) begin
      grant_o[grant_idx_o] = 1'b1;
      rr_ptr_d = (int'(grant_idx_o) == N_CH - 1) ? '0 : grant_idx_o + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) rr_ptr_q <= '0;
    else       rr_ptr_q <= rr_ptr_d;
  end

endmodule

// File: rtl/sb_header_builder.sv
// Arbitrates requester channels, builds sideband message headers and queues
// them for downstream handoff, counting completed handoffs.
module sb_header_builder
  import sb_pkg::*;
#(
  parameter int         N_CH    = 4,
  parameter int         Q_DEPTH = 4,
  parameter logic [2:0] SRCID   = DEF_SRCID,
  parameter logic [2:0] DSTID   = DEF_DSTID
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [N_CH-1:0]      i_req_valid,
  output logic [N_CH-1:0]      o_req_ready,
  input  logic [N_CH-1:0]      i_req_has_data,
  input  logic [N_CH-1:0]      i_req_dp,
  input  logic [8*N_CH-1:0]    i_req_msg_code,
  input  logic [8*N_CH-1:0]    i_req_msg_subcode,
  input  logic [16*N_CH-1:0]   i_req_msg_info,
  output logic [HDR_W-1:0]     o_header,
  output logic                 o_header_valid,
  input  logic                 i_header_ready,
  output logic [15:0]          o_sent_count
);

  localparam int IDX_W = $clog2(N_CH);
  localparam int PW    = $clog2(Q_DEPTH);

  logic [N_CH-1:0]  grant;
  logic [IDX_W-1:0] grant_idx;
  logic             full, push, pop;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]      count_q, count_d;
  logic [15:0]      sent_q, sent_d;
  logic [HDR_W-1:0] hdr_new;
  logic [HDR_W-1:0] mem_q [Q_DEPTH];

  // A pop in the same cycle never frees a slot for the incoming request.
  assign full = (count_q == (PW+1)'(Q_DEPTH));

  sb_rr_arbiter #(.N_CH(N_CH)) u_arb (
    .clk_i      (i_clk),
    .rst_i      (i_rst),
    .valid_i    (i_req_valid),
    .enable_i   (!full && !i_rst),
    .grant_o    (grant),
    .grant_idx_o(grant_idx)
  );

  assign o_req_ready = grant;
  assign push        = |grant;
  assign pop         = (count_q != '0) && i_header_ready;

  assign hdr_new = build_header(i_req_has_data[grant_idx], i_req_dp[grant_idx],
                                i_req_msg_code[int'(grant_idx)*8 +: 8],
                                i_req_msg_subcode[int'(grant_idx)*8 +: 8],
                                i_req_msg_info[int'(grant_idx)*16 +: 16],
                                SRCID, DSTID);

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (!push && pop) count_d = count_q - 1'b1;
    sent_d = (pop && sent_q != 16'hFFFF) ? sent_q + 16'd1 : sent_q;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      sent_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      sent_q   <= sent_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) mem_q[wr_ptr_q] <= hdr_new;
  end

  assign o_header_valid = (count_q != '0) && !i_rst;
  assign o_header       = o_header_valid ? mem_q[rd_ptr_q] : '0;
  assign o_sent_count   = i_rst ? 16'd0 : sent_q;

endmodule

// File: tb/tb_sb_header_builder.sv
// Directed self-checking bench for sb_header_builder.
module tb_sb_header_builder;
  localparam int N_CH = 4;

  logic                 i_clk = 1'b0;
  logic                 i_rst = 1'b1;
  logic [N_CH-1:0]      i_req_valid = '0;
  logic [N_CH-1:0]      i_req_has_data = '0;
  logic [N_CH-1:0]      i_req_dp = '0;
  logic [8*N_CH-1:0]    i_req_msg_code = '0;
  logic [8*N_CH-1:0]    i_req_msg_subcode = '0;
  logic [16*N_CH-1:0]   i_req_msg_info = '0;
  logic                 i_header_ready = 1'b0;
  logic [N_CH-1:0]      o_req_ready;
  logic [63:0]          o_header;
  logic                 o_header_valid;
  logic [15:0]          o_sent_count;

  int checks = 0;
  int errors = 0;

  always #5 i_clk = ~i_clk;

  sb_header_builder #(.N_CH(N_CH), .Q_DEPTH(4)) dut (
    .i_clk            (i_clk),
    .i_rst            (i_rst),
    .i_req_valid      (i_req_valid),
    .o_req_ready      (o_req_ready),
    .i_req_has_data   (i_req_has_data),
    .i_req_dp         (i_req_dp),
    .i_req_msg_code   (i_req_msg_code),
    .i_req_msg_subcode(i_req_msg_subcode),
    .i_req_msg_info   (i_req_msg_info),
    .o_header         (o_header),
    .o_header_valid   (o_header_valid),
    .i_header_ready   (i_header_ready),
    .o_sent_count     (o_sent_count)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end else begin
      $display("ok   %s: %h", tag, act);
    end
  endtask

  // Reference header laid out field by field, MSB first.
  function automatic logic [63:0] exp_hdr(input logic hd, input logic dp, input logic [7:0] c,
                                          input logic [7:0] s, input logic [15:0] inf);
    logic [62:0] b;
    b = {hd & dp, 3'b000, 3'b110, inf, s, 3'b010, 7'b0, c, 9'b0, hd ? 5'b11011 : 5'b10010};
    return {^b, b};
  endfunction

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic set_ch(input int k, input logic hd, input logic dp, input logic [7:0] c,
                        input logic [7:0] s, input logic [15:0] inf);
    i_req_has_data[k]          = hd;
    i_req_dp[k]                = dp;
    i_req_msg_code[8*k +: 8]    = c;
    i_req_msg_subcode[8*k +: 8] = s;
    i_req_msg_info[16*k +: 16]  = inf;
  endtask

  task automatic do_reset();
    i_req_valid    = '0;
    i_header_ready = 1'b0;
    i_rst          = 1'b1;
    tick();
    i_rst = 1'b0;
  endtask

  initial begin
    logic [63:0] h;

    // Reset state, including request gating while reset is held.
    set_ch(1, 1'b0, 1'b0, 8'hA5, 8'h02, 16'h0003);
    i_req_valid = 4'b0010;
    tick();
    tick();
    check("rst_valid", 64'(o_header_valid), 64'd0);
    check("rst_header", o_header, 64'd0);
    check("rst_ready", 64'(o_req_ready), 64'd0);
    check("rst_sent", 64'(o_sent_count), 64'd0);

    // Single request accepted on the first edge after reset release.
    i_header_ready = 1'b1;
    i_rst = 1'b0;
    #1;
    check("single_ready", 64'(o_req_ready), 64'b0010);
    tick();
    i_req_valid = '0;
    check("single_hvalid", 64'(o_header_valid), 64'd1);
    check("single_header", o_header, 64'h0600_0302_4029_4012);
    tick();
    check("single_sent", 64'(o_sent_count), 64'd1);
    check("single_empty", 64'(o_header_valid), 64'd0);
    tick();
    tick();
    check("underflow_sent", 64'(o_sent_count), 64'd1);
    check("underflow_valid", 64'(o_header_valid), 64'd0);
    check("idle_ready", 64'(o_req_ready), 64'd0);

    // Round-robin with all channels valid and the queue draining every cycle.
    do_reset();
    for (int k = 0; k < N_CH; k++) set_ch(k, 1'b0, 1'b0, 8'(8'h10 + k), 8'h00, 16'h0000);
    i_req_valid    = 4'b1111;
    i_header_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check($sformatf("rr_grant%0d", i), 64'(o_req_ready), 64'(4'b0001 << (i % 4)));
      if (i > 0) check($sformatf("rr_code%0d", i), 64'(o_header[21:14]), 64'(8'h10 + ((i - 1) % 4)));
      tick();
    end

    // Backpressure: four accepts fill the queue, then FIFO-order drain.
    do_reset();
    for (int k = 0; k < N_CH; k++)
      set_ch(k, 1'b0, 1'b0, 8'(8'h20 + k), 8'(8'h30 + k), 16'(16'h1000 + k));
    i_req_valid = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("bp_grant%0d", i), 64'(o_req_ready), 64'(4'b0001 << i));
      tick();
    end
    #1;
    check("bp_full_ready", 64'(o_req_ready), 64'd0);
    check("bp_full_valid", 64'(o_header_valid), 64'd1);
    i_req_valid    = '0;
    i_header_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("bp_pop%0d", i), o_header,
            exp_hdr(1'b0, 1'b0, 8'(8'h20 + i), 8'(8'h30 + i), 16'(16'h1000 + i)));
      tick();
    end
    check("bp_drained", 64'(o_header_valid), 64'd0);
    check("bp_sent", 64'(o_sent_count), 64'd4);

    // Data message, then a no-data message whose dp must not leak into bit 62.
    do_reset();
    set_ch(2, 1'b1, 1'b1, 8'h3C, 8'h11, 16'hBEEF);
    set_ch(3, 1'b0, 1'b1, 8'h7E, 8'h44, 16'h1234);
    i_req_valid = 4'b0100;
    tick();
    i_req_valid = 4'b1000;
    h = o_header;
    check("data_header", h, exp_hdr(1'b1, 1'b1, 8'h3C, 8'h11, 16'hBEEF));
    check("data_opcode", 64'(h[4:0]), 64'(5'b11011));
    check("data_dp", 64'(h[62]), 64'd1);
    check("data_parity", 64'(^h), 64'd0);
    tick();
    i_req_valid    = '0;
    i_header_ready = 1'b1;
    check("fifo_head_kept", o_header, exp_hdr(1'b1, 1'b1, 8'h3C, 8'h11, 16'hBEEF));
    tick();
    h = o_header;
    check("nodata_header", h, exp_hdr(1'b0, 1'b1, 8'h7E, 8'h44, 16'h1234));
    check("nodata_dp", 64'(h[62]), 64'd0);
    tick();
    check("data_sent", 64'(o_sent_count), 64'd2);

    // Reset while three headers are queued and rr_ptr has moved.
    do_reset();
    for (int k = 0; k < N_CH; k++) set_ch(k, 1'b0, 1'b0, 8'(8'h50 + k), 8'h00, 16'h0000);
    i_req_valid = 4'b1111;
    tick();
    tick();
    tick();
    check("mid_prefill", 64'(o_header_valid), 64'd1);
    i_rst = 1'b1;
    #1;
    check("mid_rst_valid", 64'(o_header_valid), 64'd0);
    check("mid_rst_header", o_header, 64'd0);
    check("mid_rst_ready", 64'(o_req_ready), 64'd0);
    tick();
    i_rst = 1'b0;
    #1;
    check("mid_first_grant", 64'(o_req_ready), 64'b0001);
    tick();
    i_req_valid = '0;
    check("mid_head_ch0", o_header, exp_hdr(1'b0, 1'b0, 8'h50, 8'h00, 16'h0000));

    // Sent-count saturation with a continuously streaming channel.
    do_reset();
    i_req_valid    = 4'b0001;
    i_header_ready = 1'b1;
    repeat (100) tick();
    check("sat_count99", 64'(o_sent_count), 64'd99);
    repeat (65440) tick();
    check("sat_hold", 64'(o_sent_count), 64'hFFFF);
    tick();
    check("sat_hold2", 64'(o_sent_count), 64'hFFFF);
    i_req_valid = '0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sb_header_builder.md
SB_HEADER_BUILDER -- requirements
Module: sb_header_builder

Interface
REQ-001 SHALL have parameter N_CH, default 4, number of requester channels (2..8).
REQ-002 SHALL have parameter Q_DEPTH, default 4, output header queue depth (power of two, >=2).
REQ-003 SHALL have parameter SRCID, default 3'b010, source ID field value.
REQ-004 SHALL have parameter DSTID, default 3'b110, destination ID field value.
REQ-005 SHALL have port i_clk, input, 1, the single clock; all logic rises on posedge.
REQ-006 SHALL have port i_rst, input, 1, reset, asynchronous, active-high.
REQ-007 SHALL have port i_req_valid, input, N_CH, per-channel message request.
REQ-008 SHALL have port o_req_ready, output, N_CH, per-channel accept; one-hot or zero.
REQ-009 SHALL have port i_req_has_data, input, N_CH, per-channel flag: message carries a 64-bit payload.
REQ-010 SHALL have port i_req_dp, input, N_CH, per-channel payload parity bit.
REQ-011 SHALL have port i_req_msg_code, input, 8*N_CH, per-channel MsgCode, with channel k at bits [8k+7:8k].
REQ-012 SHALL have port i_req_msg_subcode, input, 8*N_CH, per-channel MsgSubcode.
REQ-013 SHALL have port i_req_msg_info, input, 16*N_CH, per-channel MsgInfo.
REQ-014 SHALL have port o_header, output, 64, the head-of-queue header.
REQ-015 SHALL have port o_header_valid, output, 1, the queue is non-empty.
REQ-016 SHALL have port i_header_ready, input, 1, downstream accepts o_header.
REQ-017 SHALL have port o_sent_count, output, 16, saturating count of headers handed off.

Function
REQ-018 SHALL arbitrate round-robin: the grant goes to the first valid channel at or after rr_ptr, modulo N_CH.
REQ-019 SHALL assert o_req_ready[g] only for the granted channel g, and only when the queue is not full; a pop in the same cycle does not free a slot.
REQ-020 SHALL define acceptance as i_req_valid[g] && o_req_ready[g]; on acceptance, rr_ptr becomes (g+1) mod N_CH; otherwise rr_ptr holds.
REQ-021 SHALL build the header on acceptance with these fields:
- opcode[4:0] = 5'b11011 if has_data, else 5'b10010
- [13:5] = 0
- [21:14] = MsgCode
- [28:22] = 0
- [31:29] = SRCID
- [39:32] = MsgSubcode
- [55:40] = MsgInfo
- [58:56] = DSTID
- [61:59] = 0
REQ-022 SHALL set bit 62 (DP) to i_req_dp[g] when has_data is 1, and to 0 otherwise.
REQ-023 SHALL set bit 63 (CP) to the XOR of bits [62:0], so that the 64-bit header has even parity.
REQ-024 SHALL push the built header into a FIFO of Q_DEPTH entries; latency from acceptance in cycle N to o_header_valid is cycle N+1 when the queue was empty.
REQ-025 SHALL present o_header combinationally from the queue head; o_header is stable while o_header_valid && !i_header_ready.
REQ-026 SHALL pop on o_header_valid && i_header_ready and increment o_sent_count, saturating at 16'hFFFF.
REQ-027 SHALL handle a push and a pop in the same cycle (queue not full) with the count unchanged, correct pointers, and FIFO order preserved.
REQ-028 SHALL wrap the read and write pointers modulo Q_DEPTH; full = (count == Q_DEPTH) and empty = (count == 0).
REQ-029 SHALL ignore i_header_ready while empty, with no underflow and no counter change.
REQ-030 SHALL keep o_req_ready at zero when no channel is valid.

Reset
REQ-031 SHALL, while i_rst is high, hold all outputs at 0 regardless of the clock: o_header = 0, o_header_valid = 0, o_req_ready = 0, o_sent_count = 0.
REQ-032 SHALL, on reset asserted mid-operation, discard all queued headers and clear rr_ptr, the pointers and the count to 0.
REQ-033 SHALL accept the first request in the first clock edge after i_rst deasserts.

Structure
REQ-034 SHALL place the following in shared package sb_pkg:
- opcode constants (OPC_MSG_NODATA = 5'b10010, OPC_MSG_DATA64 = 5'b11011)
- header field bit-position constants
- HDR_W = 64
- the default SRCID and DSTID values
REQ-035 SHALL instantiate one sub-module, sb_rr_arbiter (parameter N_CH; inputs valid, enable; outputs one-hot grant and grant index; internal rr_ptr).

Verification
REQ-036 SHALL cover single request: ch1 valid, code 8'hA5, subcode 8'h02, info 16'h0003, no data, ready=1 -> next cycle o_header = {CP, 1'b0, 3'b0, 3'b110, 16'h0003, 8'h02, 3'b010, 7'b0, 8'hA5, 9'b0, 5'b10010} with the correct CP, and o_sent_count = 1 after the handoff.
REQ-037 SHALL cover round-robin fairness: all 4 channels valid continuously, ready=1 -> grant order 0, 1, 2, 3, 0, with no channel granted twice in 4 accepts.
REQ-038 SHALL cover backpressure and full: i_header_ready=0 with Q_DEPTH=4 -> 4 accepts, then o_req_ready = 0; releasing ready -> headers pop in FIFO order.
REQ-039 SHALL cover a data message: has_data=1, dp=1 -> opcode 5'b11011, bit 62 = 1, and even parity over all 64 bits.
REQ-040 SHALL cover reset mid-operation: assert i_rst with 3 queued headers -> o_header_valid = 0 immediately, count = 0, and the first post-reset grant goes to channel 0.
REQ-041 SHALL cover counter saturation: force 65537 handoffs -> o_sent_count holds at 16'hFFFF.
